exception_commit: RTL

Registered, parametrised exception-commit stage at the MEM/WB boundary, successor to the combinational exception-type encoder. Merges the MEM-stage exception flags, address errors and a configurable number of hardware interrupt lines into one prioritised commit decision. Captures ExcCode, EPC, BD and BadVAddr for CP0, then runs a pipeline-flush sequence of parameterised length with the redirect PC.

---
 rtl/exception_commit.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/exception_commit.sv
// Registered exception-commit stage at MEM/WB: prioritises interrupts and exceptions, captures CP0 data, runs the flush FSM.
// Optional EXC_INT_SYNC_EN: add a 2-flop synchroniser on each hw_int_i bit.
module exception_commit #(
    parameter int          NUM_HW_INT   = 6,
    parameter int          FLUSH_CYCLES = 1,
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  mem_valid_i,
    input  logic                  stall_i,
    input  logic [31:0]           mem_pc_i,
    input  logic                  mem_bd_i,
    input  logic [31:0]           exception_type_i,
    input  logic                  adel_i,
    input  logic                  ades_i,
    input  logic [31:0]           bad_addr_i,
    input  logic [NUM_HW_INT-1:0] hw_int_i,
    input  logic [31:0]           cp0_status_i,
    input  logic [31:0]           cp0_cause_i,
    input  logic [31:0]           cp0_epc_i,
    output logic                  exc_valid_o,
    output logic [4:0]            exc_code_o,
    output logic [31:0]           exc_epc_o,
    output logic                  exc_bd_o,
    output logic                  exc_badvaddr_we_o,
    output logic [31:0]           exc_badvaddr_o,
    output logic                  exc_eret_o,
    output logic                  flush_o,
    output logic [31:0]           flush_pc_o,
    output logic                  int_pending_o
);
    typedef enum logic {IDLE, FLUSH} state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        valid_q, valid_d, eret_q, eret_d, bv_we_q, bv_we_d, bd_q, bd_d;
    logic [4:0]  code_q, code_d;
    logic [31:0] epc_q, epc_d, bv_q, bv_d, fpc_q, fpc_d;

    logic [NUM_HW_INT-1:0] hw_int;
    logic [7:0]            ip;
    logic                  hit, is_eret, need_bv, commit;
    logic [4:0]            code;
    logic [31:0]           bv;

`ifdef EXC_INT_SYNC_EN
    logic [NUM_HW_INT-1:0] sync1_q, sync2_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= hw_int_i;
            sync2_q <= sync1_q;
        end
    end
    assign hw_int = sync2_q;
`else
    assign hw_int = hw_int_i;
`endif

    always_comb begin
        ip                    = '0;
        ip[1:0]               = cp0_cause_i[9:8];
        ip[2 +: NUM_HW_INT]   = hw_int;
    end

    assign int_pending_o = (|(ip & cp0_status_i[15:8])) & cp0_status_i[0] & ~cp0_status_i[1];

    // Fixed priority decode; an interrupt preempts whatever the instruction raised.
    always_comb begin
        hit     = 1'b1;
        is_eret = 1'b0;
        need_bv = 1'b0;
        code    = 5'h00;
        bv      = bad_addr_i;
        if (int_pending_o)            code = 5'h00;
        else if (exception_type_i[14]) begin code = 5'h04; need_bv = 1'b1; bv = mem_pc_i; end
        else if (adel_i)               begin code = 5'h04; need_bv = 1'b1; end
        else if (ades_i)               begin code = 5'h05; need_bv = 1'b1; end
        else if (exception_type_i[8])  code = 5'h08;
        else if (exception_type_i[9])  code = 5'h0a;
        else if (exception_type_i[13]) code = 5'h09;
        else if (exception_type_i[11]) code = 5'h0c;
        else if (exception_type_i[10]) code = 5'h0d;
        else if (exception_type_i[12]) is_eret = 1'b1;
        else                           hit = 1'b0;
    end

    assign commit = (state_q == IDLE) & mem_valid_i & ~stall_i & hit;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = commit & ~is_eret;
        eret_d  = commit & is_eret;
        bv_we_d = commit & need_bv;
        code_d  = code_q;
        epc_d   = epc_q;
        bd_d    = bd_q;
        bv_d    = bv_q;
        fpc_d   = fpc_q;
        case (state_q)
            IDLE: if (commit) begin
                state_d = FLUSH;
                cnt_d   = 2'(FLUSH_CYCLES - 1);
                fpc_d   = is_eret ? cp0_epc_i : EXC_VECTOR;
                if (!is_eret) begin
                    code_d = code;
                    epc_d  = mem_bd_i ? mem_pc_i - 32'd4 : mem_pc_i;
                    bd_d   = mem_bd_i;
                end
                if (need_bv) bv_d = bv;
            end
            FLUSH: begin
                if (cnt_q == 2'd0) state_d = IDLE;
                else               cnt_d   = cnt_q - 2'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            eret_q  <= 1'b0;
            bv_we_q <= 1'b0;
            code_q  <= '0;
            epc_q   <= '0;
            bd_q    <= 1'b0;
            bv_q    <= '0;
            fpc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            eret_q  <= eret_d;
            bv_we_q <= bv_we_d;
            code_q  <= code_d;
            epc_q   <= epc_d;
            bd_q    <= bd_d;
            bv_q    <= bv_d;
            fpc_q   <= fpc_d;
        end
    end

    // Decoded from the state register so reset drops the flush asynchronously.
    assign flush_o           = (state_q == FLUSH);
    assign exc_valid_o       = valid_q;
    assign exc_eret_o        = eret_q;
    assign exc_badvaddr_we_o = bv_we_q;
    assign exc_code_o        = code_q;
    assign exc_epc_o         = epc_q;
    assign exc_bd_o          = bd_q;
    assign exc_badvaddr_o    = bv_q;
    assign flush_pc_o        = fpc_q;

    logic unused_bits;
    assign unused_bits = ^{cp0_status_i[31:16], cp0_status_i[7:2], cp0_cause_i[31:10],
                           cp0_cause_i[7:0], exception_type_i[31:15], exception_type_i[7:0]};
endmodule
